// File: rtl/xadc_scan_sequencer.sv
// xadc_scan_sequencer: owns the XADC DRP port. On each end-of-sequence it reads
// VP/VN plus the auxiliary channels, keeps the 12-bit codes in a channel bank,
// streams every result with its channel index and serves random bank reads.
module xadc_scan_sequencer #(
  parameter int CHANNELS = 13,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eos_in,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do,
  output logic        sample_valid,
  output logic [3:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic        scan_done,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  overrun_cnt,
  input  logic [3:0]  rd_ch,
  output logic [11:0] rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

  localparam logic [3:0]  LAST_IDX = 4'(CHANNELS - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [4:0]  NUM_CH   = 5'(CHANNELS);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  sample_ch_q, sample_ch_d;
  logic [11:0] sample_data_q, sample_data_d;
  logic        scan_done_q, scan_done_d;
  logic        timeout_err_q, timeout_err_d;
  logic [7:0]  overrun_q, overrun_d;
  logic [11:0] rd_data_q, rd_data_d;
  logic [11:0] bank_q [CHANNELS];
  logic [11:0] bank_d [CHANNELS];
  logic        advance;

  // Low nibble of the conversion register is below the 12-bit code.
  logic unused_do_bits;
  assign unused_do_bits = ^drp_do[3:0];

  // Index 0 is VP/VN, the rest walk up from VAUX0.
  function automatic logic [6:0] chan_addr(input logic [3:0] idx);
    if (idx == 4'd0) return 7'h03;
    return 7'h0F + {3'b000, idx};
  endfunction

  assign drp_den      = (state_q == S_ISSUE);
  assign drp_daddr    = (state_q == S_IDLE) ? 7'h00 : chan_addr(idx_q);
  assign sample_valid = (state_q == S_STORE);
  assign sample_ch    = sample_ch_q;
  assign sample_data  = sample_data_q;
  assign scan_done    = scan_done_q;
  // The scan_done cycle already sits in IDLE but still counts as busy, so an
  // eos_in there is an overrun rather than a new scan.
  assign busy         = (state_q != S_IDLE) || scan_done_q;
  assign timeout_err  = timeout_err_q;
  assign overrun_cnt  = overrun_q;
  assign rd_data      = rd_data_q;

  // Next-state, channel walk, timeout, bank write and sticky status logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    sample_ch_d   = sample_ch_q;
    sample_data_d = sample_data_q;
    scan_done_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    overrun_d     = overrun_q;
    bank_d        = bank_q;
    advance       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (eos_in && !scan_done_q) begin
          idx_d   = 4'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (drp_drdy) begin
          sample_data_d = drp_do[15:4];
          sample_ch_d   = idx_q;
          state_d       = S_STORE;
        end else if (cnt_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          advance       = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STORE: begin
        bank_d[idx_q] = sample_data_q;
        advance       = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == LAST_IDX) begin
        scan_done_d = 1'b1;
        state_d     = S_IDLE;
      end else begin
        idx_d   = idx_q + 4'd1;
        state_d = S_ISSUE;
      end
    end

    if (eos_in && busy && (overrun_q != 8'hFF)) overrun_d = overrun_q + 8'd1;

    rd_data_d = ({1'b0, rd_ch} < NUM_CH) ? bank_q[rd_ch] : 12'h000;
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= 4'd0;
      cnt_q         <= 16'd0;
      sample_ch_q   <= 4'd0;
      sample_data_q <= 12'h000;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 8'd0;
      rd_data_q     <= 12'h000;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      sample_ch_q   <= sample_ch_d;
      sample_data_q <= sample_data_d;
      scan_done_q   <= scan_done_d;
      timeout_err_q <= timeout_err_d;
      overrun_q     <= overrun_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Channel bank; cleared on reset so a reset scan never shows stale codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) bank_q[i] <= 12'h000;
    end else begin
      bank_q <= bank_d;
    end
  end

endmodule

// File: tb/tb_xadc_scan_sequencer.sv
// Bench for xadc_scan_sequencer: a DRP responder model plus a scoreboard of
// expected samples, driven by one task per scenario.
`timescale 1ns/1ps
module tb_xadc_scan_sequencer;
  localparam int CHANNELS = 13;
  localparam int TIMEOUT  = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        eos_in = 1'b0;
  logic        drp_drdy = 1'b0;
  logic [15:0] drp_do = 16'hDEAD;
  logic [3:0]  rd_ch = 4'd0;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        sample_valid;
  logic [3:0]  sample_ch;
  logic [11:0] sample_data;
  logic        scan_done;
  logic        busy;
  logic        timeout_err;
  logic [7:0]  overrun_cnt;
  logic [11:0] rd_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [15:0] drp_val [16];
  logic [11:0] bank_m [16];
  logic [15:0] sb [$];
  int drdy_delay = 4;
  int withhold = -1;
  int exp_idx = 0;
  int pend_cnt = 0;
  logic [15:0] pend_data = 16'h0000;
  int den_n = 0, strobe_n = 0, done_n = 0;
  int den_cyc [16];
  int strobe_cyc [16];
  int last_strobe_cyc = 0, done_cyc = 0;

  xadc_scan_sequencer #(.CHANNELS(CHANNELS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .eos_in(eos_in),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_drdy(drp_drdy), .drp_do(drp_do),
    .sample_valid(sample_valid), .sample_ch(sample_ch), .sample_data(sample_data),
    .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err),
    .overrun_cnt(overrun_cnt), .rd_ch(rd_ch), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] addr_m(input int k);
    if (k == 0) return 7'h03;
    return 7'(16 + k - 1);
  endfunction

  // DRP responder and scoreboard, evaluated on the falling edge.
  always @(negedge clk) begin : monitor
    logic [15:0] e;
    drp_drdy = 1'b0;
    drp_do   = 16'hDEAD;
    if (!rst) begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          drp_drdy = 1'b1;
          drp_do   = pend_data;
        end
      end
      if (drp_den) begin
        vectors++;
        if (exp_idx >= CHANNELS || drp_daddr !== addr_m(exp_idx)) begin
          miscompares++;
          $display("FAIL den_addr idx=%0d got %h want %h", exp_idx, drp_daddr, addr_m(exp_idx));
        end
        if (exp_idx < 16) begin
          den_cyc[exp_idx] = cyc;
          if (exp_idx != withhold) begin
            pend_cnt  = drdy_delay;
            pend_data = drp_val[exp_idx];
            sb.push_back({4'(exp_idx), drp_val[exp_idx][15:4]});
          end
        end
        den_n++;
        exp_idx++;
      end
      if (sample_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_strobe got ch=%0d data=%h want none", sample_ch, sample_data);
        end else begin
          e = sb.pop_front();
          if ({sample_ch, sample_data} !== e) begin
            miscompares++;
            $display("FAIL sample got ch=%0d data=%h want ch=%0d data=%h",
                     sample_ch, sample_data, e[15:12], e[11:0]);
          end
          bank_m[e[15:12]] = e[11:0];
        end
        if (strobe_n < 16) strobe_cyc[strobe_n] = cyc;
        strobe_n++;
        last_strobe_cyc = cyc;
      end
      if (scan_done) begin
        vectors++;
        if (sb.size() != 0 || exp_idx != CHANNELS) begin
          miscompares++;
          $display("FAIL scan_done_point got idx=%0d pending=%0d want idx=%0d pending=0",
                   exp_idx, sb.size(), CHANNELS);
        end
        done_n++;
        done_cyc = cyc;
        exp_idx = 0;
      end
    end
  end

  task automatic clear_stats();
    den_n = 0; strobe_n = 0; done_n = 0;
  endtask

  task automatic pulse_eos(output int c0);
    @(negedge clk);
    eos_in = 1'b1;
    c0 = cyc;
    @(negedge clk);
    eos_in = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int start;
    int n;
    start = done_n;
    n = 0;
    while (done_n == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (done_n == start) begin
      miscompares++;
      $display("FAIL %s_wait got no scan_done want scan_done within %0d cycles", tag, budget);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({drp_den, drp_daddr, sample_valid, scan_done, busy} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl got den=%b addr=%h sv=%b done=%b busy=%b want all 0",
               drp_den, drp_daddr, sample_valid, scan_done, busy);
    end
    vectors++;
    if ({timeout_err, overrun_cnt} !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_status got terr=%b ovr=%0d want 0", timeout_err, overrun_cnt);
    end
    vectors++;
    if ({sample_ch, sample_data, rd_data} !== 28'd0) begin
      miscompares++;
      $display("FAIL reset_data got ch=%0d data=%h rd=%h want 0", sample_ch, sample_data, rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    int c0;
    for (int k = 0; k < 16; k++) drp_val[k] = 16'hABC0;
    drdy_delay = 4; withhold = -1;
    clear_stats();
    pulse_eos(c0);
    wait_done(400, "nominal");
    repeat (4) @(negedge clk);
    vectors++;
    if (den_n != CHANNELS || strobe_n != CHANNELS || done_n != 1) begin
      miscompares++;
      $display("FAIL nominal_counts got den=%0d strobe=%0d done=%0d want %0d/%0d/1",
               den_n, strobe_n, done_n, CHANNELS, CHANNELS);
    end
    vectors++;
    if (done_cyc != last_strobe_cyc + 1) begin
      miscompares++;
      $display("FAIL nominal_done_lat got %0d want %0d", done_cyc, last_strobe_cyc + 1);
    end
    vectors++;
    if (den_cyc[1] - den_cyc[0] != drdy_delay + 2) begin
      miscompares++;
      $display("FAIL nominal_den_gap got %0d want %0d", den_cyc[1] - den_cyc[0], drdy_delay + 2);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL nominal_idle_busy got %b want 0", busy);
    end
    rd_ch = 4'd5;
    @(negedge clk);
    vectors++;
    if (rd_data !== 12'hABC) begin
      miscompares++;
      $display("FAIL nominal_rd5 got %h want abc", rd_data);
    end
  endtask

  task automatic test_latency();
    int c0;
    for (int k = 0; k < 16; k++) drp_val[k] = {4'(k), 8'h5A, 4'h7};
    drdy_delay = 2;
    clear_stats();
    pulse_eos(c0);
    wait_done(400, "latency");
    vectors++;
    if (den_cyc[0] != c0 + 1 || strobe_cyc[0] != c0 + 4 || den_cyc[1] != c0 + 5) begin
      miscompares++;
      $display("FAIL latency got den0=%0d sv0=%0d den1=%0d want %0d/%0d/%0d",
               den_cyc[0] - c0, strobe_cyc[0] - c0, den_cyc[1] - c0, 1, 4, 5);
    end
  endtask

  task automatic test_timeout();
    int c0;
    for (int k = 0; k < 16; k++) drp_val[k] = {4'(k), 8'hC3, 4'h1};
    drp_val[4] = 16'h1230;
    drdy_delay = 3; withhold = -1;
    clear_stats();
    pulse_eos(c0);
    wait_done(400, "preload");
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pre_err got %b want 0", timeout_err);
    end
    for (int k = 0; k < 16; k++) drp_val[k] = {4'(k), 8'h3C, 4'h2};
    withhold = 4;
    clear_stats();
    pulse_eos(c0);
    wait_done(3000, "timeout");
    withhold = -1;
    vectors++;
    if (strobe_n != CHANNELS - 1 || done_n != 1) begin
      miscompares++;
      $display("FAIL timeout_counts got strobe=%0d done=%0d want %0d/1", strobe_n, done_n, CHANNELS - 1);
    end
    vectors++;
    if (timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_err got %b want 1", timeout_err);
    end
    vectors++;
    if (den_cyc[5] - den_cyc[4] != TIMEOUT + 1) begin
      miscompares++;
      $display("FAIL timeout_wait got %0d want %0d", den_cyc[5] - den_cyc[4], TIMEOUT + 1);
    end
    rd_ch = 4'd4;
    @(negedge clk);
    vectors++;
    if (rd_data !== 12'h123) begin
      miscompares++;
      $display("FAIL timeout_bank4 got %h want 123", rd_data);
    end
    rd_ch = 4'd5;
    @(negedge clk);
    vectors++;
    if (rd_data !== bank_m[5] || bank_m[5] !== 12'h53C) begin
      miscompares++;
      $display("FAIL timeout_bank5 got %h want 53c", rd_data);
    end
  endtask

  task automatic test_out_of_range();
    logic [11:0] want;
    for (int r = 12; r < 16; r++) begin
      rd_ch = 4'(r);
      want = (r < CHANNELS) ? bank_m[r] : 12'h000;
      @(negedge clk);
      vectors++;
      if (rd_data !== want) begin
        miscompares++;
        $display("FAIL rd_range ch=%0d got %h want %h", r, rd_data, want);
      end
    end
  endtask

  task automatic test_overrun();
    int c0;
    int n;
    vectors++;
    if (overrun_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL overrun_start got %0d want 0", overrun_cnt);
    end
    for (int k = 0; k < 16; k++) drp_val[k] = {4'(k), 8'h96, 4'h4};
    drdy_delay = 4;
    clear_stats();
    pulse_eos(c0);
    n = 0;
    while (den_n == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) begin
      @(negedge clk); eos_in = 1'b1;
      @(negedge clk); eos_in = 1'b0;
    end
    vectors++;
    if (overrun_cnt !== 8'd10) begin
      miscompares++;
      $display("FAIL overrun_10 got %0d want 10", overrun_cnt);
    end
    wait_done(400, "overrun_a");
    vectors++;
    if (den_n != CHANNELS || done_n != 1) begin
      miscompares++;
      $display("FAIL overrun_no_restart got den=%0d done=%0d want %0d/1", den_n, done_n, CHANNELS);
    end
    drdy_delay = 1;
    @(negedge clk);
    eos_in = 1'b1;
    repeat (400) @(negedge clk);
    eos_in = 1'b0;
    wait_done(200, "overrun_b");
    vectors++;
    if (overrun_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL overrun_sat got %0d want 255", overrun_cnt);
    end
    vectors++;
    if (timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky got %b want 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    int n;
    for (int k = 0; k < 16; k++) drp_val[k] = {4'(k), 8'h77, 4'h3};
    drdy_delay = 4;
    clear_stats();
    pulse_eos(c0);
    n = 0;
    while (den_n < 8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    pend_cnt = 0;
    sb.delete();
    exp_idx = 0;
    for (int k = 0; k < 16; k++) bank_m[k] = 12'h000;
    #1;
    vectors++;
    if (drp_den !== 1'b0 || busy !== 1'b0 || drp_daddr !== 7'h00) begin
      miscompares++;
      $display("FAIL midrst_async got den=%b busy=%b addr=%h want 0/0/00", drp_den, busy, drp_daddr);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (overrun_cnt !== 8'd0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_status got ovr=%0d terr=%b want 0/0", overrun_cnt, timeout_err);
    end
    rst = 1'b0;
    for (int r = 0; r < 16; r++) begin
      rd_ch = 4'(r);
      @(negedge clk);
      vectors++;
      if (rd_data !== 12'h000) begin
        miscompares++;
        $display("FAIL midrst_bank ch=%0d got %h want 000", r, rd_data);
      end
    end
    vectors++;
    if (done_n != 0) begin
      miscompares++;
      $display("FAIL midrst_no_done got %0d want 0", done_n);
    end
    clear_stats();
    pulse_eos(c0);
    wait_done(400, "midrst_rescan");
    vectors++;
    if (den_n != CHANNELS || strobe_n != CHANNELS) begin
      miscompares++;
      $display("FAIL midrst_rescan got den=%0d strobe=%0d want %0d", den_n, strobe_n, CHANNELS);
    end
    rd_ch = 4'd7;
    @(negedge clk);
    vectors++;
    if (rd_data !== 12'h777) begin
      miscompares++;
      $display("FAIL midrst_rd7 got %h want 777", rd_data);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got no finish want finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      drp_val[k] = 16'h0000;
      bank_m[k]  = 12'h000;
      den_cyc[k] = 0;
      strobe_cyc[k] = 0;
    end
    test_reset();
    test_nominal();
    test_latency();
    test_timeout();
    test_out_of_range();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xadc_scan_sequencer.md
Name: xadc_scan_sequencer

Overview:
Upstream stage that owns the XADC DRP port. On each XADC end-of-sequence it reads a fixed list of conversion registers: VP/VN plus auxiliary channels. It stores the 12-bit codes in a channel bank and streams each result, with its channel index, to the downstream voltage scaler / BCD path. A random-access read port serves the display multiplexer.

Parameters:
CHANNELS, 13, number of channels scanned per sequence (1..16)
TIMEOUT, 255, max clk cycles to wait for drp_drdy before skipping a channel (1..65535)

Ports:
clk  in  1  system clock, also the DRP dclk
rst  in  1  asynchronous, active-high reset
eos_in  in  1  XADC end-of-sequence pulse; scan trigger
drp_daddr  out  7  DRP address
drp_den  out  1  DRP enable, one-cycle pulse
drp_drdy  in  1  DRP data-ready
drp_do  in  16  DRP read data
sample_valid  out  1  one-cycle strobe; a new result is on sample_ch/sample_data
sample_ch  out  4  channel index of the current result
sample_data  out  12  result code, drp_do[15:4]
scan_done  out  1  one-cycle pulse after the last channel of a scan is processed
busy  out  1  high while a scan is in progress
timeout_err  out  1  sticky; set on any DRP timeout
overrun_cnt  out  8  saturating count of eos_in pulses ignored while busy
rd_ch  in  4  bank read index
rd_data  out  12  registered bank read data

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0, drp_daddr is 7'h00, FSM is IDLE.
  - Channel index, timeout counter and all bank entries are 0.
- Address map:
  - Index 0 maps to 7'h03 (VP/VN).
  - Index k (1..CHANNELS-1) maps to 7'h10+(k-1) (VAUX0..).
- FSM states: IDLE, ISSUE, WAIT, STORE.
- IDLE: busy=0. If eos_in=1, set idx=0 and go to ISSUE.
- ISSUE: drp_den=1 for exactly this cycle, with drp_daddr=map(idx). Clear the timeout counter and go to WAIT.
- WAIT:
  - drp_drdy=1: capture drp_do[15:4] and go to STORE.
  - Otherwise increment the counter. When counter==TIMEOUT, set timeout_err, leave the bank entry unchanged, emit no sample_valid, and advance as in STORE's next-index rule.
- STORE: write bank[idx], and drive sample_valid=1, sample_ch=idx, sample_data=captured value for this one cycle.
- Next-index rule (after STORE or a timeout):
  - If idx==CHANNELS-1, pulse scan_done in the next cycle and go to IDLE.
  - Otherwise set idx=idx+1 and go to ISSUE.
- busy=1 in ISSUE, WAIT and STORE, and in the scan_done cycle.
- Latency:
  - eos_in at cycle 0 gives drp_den at cycle 1.
  - drdy at cycle t gives sample_valid at t+1. The bank entry is visible on rd_data at t+3 (write at t+1 edge, registered read).
- drp_drdy outside WAIT is ignored.
- sample_ch and sample_data hold their last values between strobes.
- eos_in while busy: the scan is not restarted and overrun_cnt increments, saturating at 255.
- eos_in in the same cycle the FSM returns to IDLE counts as an overrun. Only eos_in sampled in IDLE starts a scan.
- rd_data is registered, 1-cycle latency. If rd_ch >= CHANNELS, rd_data=0. A read of an entry being written in the same cycle returns the old value.
- timeout_err and overrun_cnt clear only on rst.
- rst mid-scan aborts immediately: no scan_done, bank cleared, den deasserted asynchronously.

Test Plan:
1. Nominal scan: single eos_in, model returns drp_do=16'hABC0 with drdy 4 cycles after each den -> 13 den pulses with addrs 03,10..1B in order; sample_data=12'hABC with sample_ch 0..12; scan_done once, 1 cycle after the ch12 strobe; rd_ch=5 -> 12'hABC.
2. Latency check: eos at cycle 0, drdy at cycle 3 -> den at cycle 1, sample_valid at cycle 4 with ch 0, second den at cycle 5.
3. Timeout: model withholds drdy for index 4 only, bank[4] preloaded 12'h123 by a prior scan -> WAIT lasts TIMEOUT cycles; no strobe for ch 4; timeout_err=1; bank[4] still 12'h123; scan completes through ch 12.
4. Overrun: 300 eos_in pulses while busy across repeated scans -> overrun_cnt saturates at 255; no scan restarts mid-scan.
5. Reset mid-scan: assert rst during WAIT of ch 7 -> den=0 and busy=0 immediately; rd_data=0 for all channels; next eos starts at idx 0 with addr 03.
6. Out-of-range read: rd_ch=14 and rd_ch=15 -> rd_data=0.
